// File: rtl/dog_pkg.sv
// Shared constants for the dog sprite path: sprite geometry, palette format and
// the animation frame codes agreed with the dog animation controller.
package dog_pkg;

  localparam int unsigned SPRITE_W        = 64;
  localparam int unsigned SPRITE_H        = 48;
  localparam int unsigned NUM_FRAMES      = 9;
  localparam int unsigned PIX_W           = 4;
  localparam int unsigned TRANSPARENT_IDX = 0;
  localparam int unsigned FRAME_CODE_W    = 5;

  typedef enum logic [FRAME_CODE_W-1:0] {
    FR_SIT       = 5'd0,
    FR_WALK1     = 5'd1,
    FR_WALK2     = 5'd2,
    FR_WALK3     = 5'd3,
    FR_SNIFF1    = 5'd4,
    FR_SNIFF2    = 5'd5,
    FR_SURPRISED = 5'd6,
    FR_JUMP1     = 5'd7,
    FR_JUMP2     = 5'd8
  } dog_frame_e;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register chain with async reset; q is d delayed by DEPTH cycles.
module pipe_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/dog_sprite_renderer.sv
// Per-pixel dog sprite lookup: frame-stable shadow of position/frame, ROM address
// generation, ROM-latency alignment and transparency keying for the colour mapper.
module dog_sprite_renderer #(
  parameter int unsigned SPRITE_W        = dog_pkg::SPRITE_W,
  parameter int unsigned SPRITE_H        = dog_pkg::SPRITE_H,
  parameter int unsigned NUM_FRAMES      = dog_pkg::NUM_FRAMES,
  parameter int unsigned PIX_W           = dog_pkg::PIX_W,
  parameter int unsigned TRANSPARENT_IDX = dog_pkg::TRANSPARENT_IDX,
  parameter int unsigned ROM_LATENCY     = 2,
  localparam int unsigned ADDR_W         = $clog2(NUM_FRAMES * SPRITE_W * SPRITE_H)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [9:0]        Dog_X,
  input  logic [9:0]        Dog_Y,
  input  logic [4:0]        Frame,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pix_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic              dog_on,
  output logic [PIX_W-1:0]  dog_idx,
  output logic              frame_err
);

  localparam int unsigned FRAME_W = $clog2(NUM_FRAMES);

  logic [9:0]         sh_x;
  logic [9:0]         sh_y;
  logic [FRAME_W-1:0] sh_frame;
  logic               shadow_valid;
  logic [10:0]        relx_c;
  logic [10:0]        rely_c;
  logic               hit_c;
  logic [ADDR_W-1:0]  addr_c;
  logic               hit_q;
  logic               hit_d;
  logic               opaque_c;

  // Shadow registers: only frame_start updates them, so a frame never tears
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sh_x         <= '0;
      sh_y         <= '0;
      sh_frame     <= '0;
      shadow_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else if (frame_start) begin
      sh_x         <= Dog_X;
      sh_y         <= Dog_Y;
      shadow_valid <= 1'b1;
      if (Frame >= 5'(NUM_FRAMES)) begin
        sh_frame  <= '0;
        frame_err <= 1'b1;
      end else begin
        sh_frame  <= FRAME_W'(Frame);
      end
    end
  end

  // 11-bit differences: a negative offset reads as >= 1024 unsigned, so one
  // unsigned compare rejects both left/above and right/below of the sprite
  always_comb begin
    relx_c = {1'b0, DrawX} - {1'b0, sh_x};
    rely_c = {1'b0, DrawY} - {1'b0, sh_y};
    hit_c  = pix_valid && shadow_valid &&
             (relx_c < 11'(SPRITE_W)) && (rely_c < 11'(SPRITE_H));
    addr_c = ADDR_W'(sh_frame) * ADDR_W'(SPRITE_W * SPRITE_H) +
             ADDR_W'(rely_c) * ADDR_W'(SPRITE_W) + ADDR_W'(relx_c);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_q    <= 1'b0;
      rom_addr <= '0;
    end else begin
      hit_q <= hit_c;
      if (hit_c) rom_addr <= addr_c;
    end
  end

  pipe_delay #(
    .WIDTH (1),
    .DEPTH (ROM_LATENCY)
  ) u_hit_dly (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (hit_q),
    .q     (hit_d)
  );

  assign opaque_c = hit_d && (rom_data != PIX_W'(TRANSPARENT_IDX));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dog_on  <= 1'b0;
      dog_idx <= '0;
    end else begin
      dog_on  <= opaque_c;
      dog_idx <= opaque_c ? rom_data : '0;
    end
  end

endmodule

// File: tb/tb_dog_sprite_renderer.sv
// Directed bench for dog_sprite_renderer with a 2-cycle behavioural sprite ROM
// whose texel is addr[3:0] ^ 5 (so address 5 is transparent).
module tb_dog_sprite_renderer;
  import dog_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic [9:0]  Dog_X;
  logic [9:0]  Dog_Y;
  logic [4:0]  Frame;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        pix_valid;
  logic [14:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  rom_d1;
  logic        dog_on;
  logic [3:0]  dog_idx;
  logic        frame_err;

  int n_cmp = 0;
  int n_err = 0;

  dog_sprite_renderer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .Dog_X       (Dog_X),
    .Dog_Y       (Dog_Y),
    .Frame       (Frame),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .pix_valid   (pix_valid),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .dog_on      (dog_on),
    .dog_idx     (dog_idx),
    .frame_err   (frame_err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] rom_f(input logic [14:0] a);
    return a[3:0] ^ 4'h5;
  endfunction

  always @(posedge Clk) begin
    rom_d1   <= rom_f(rom_addr);
    rom_data <= rom_d1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic latch(input int x, input int y, input int f);
    @(negedge Clk);
    Dog_X = 10'(x); Dog_Y = 10'(y); Frame = 5'(f); frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
  endtask

  // One isolated pixel: check rom_addr after its edge, outputs three edges later
  task automatic px(input string tag, input int x, input int y, input bit fs,
                    input int exp_addr, input bit exp_on, input int exp_idx);
    @(negedge Clk);
    DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1'b1; frame_start = fs;
    @(posedge Clk); #1;
    pix_valid = 1'b0; frame_start = 1'b0;
    chk({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    repeat (3) @(posedge Clk);
    #1;
    chk({tag, ".on"}, 32'(dog_on), 32'(exp_on));
    chk({tag, ".idx"}, 32'(dog_idx), 32'(exp_idx));
  endtask

  int stream_idx [3] = '{4, 7, 6};

  initial begin
    Reset = 1'b1; frame_start = 1'b0; Dog_X = '0; Dog_Y = '0; Frame = '0;
    DrawX = '0; DrawY = '0; pix_valid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.addr", 32'(rom_addr), 0);
    chk("rst.on", 32'(dog_on), 0);
    chk("rst.idx", 32'(dog_idx), 0);
    chk("rst.err", 32'(frame_err), 0);
    @(negedge Clk) Reset = 1'b0;

    // No shadow yet: (0,0) would hit a sprite at (0,0)
    px("no_shadow", 0, 0, 1'b0, 0, 1'b0, 0);

    latch(11, 300, FR_SIT);
    px("first", 11, 300, 1'b0, 0, 1'b1, 5);

    latch(43, 300, FR_SNIFF1);
    px("sniff", 50, 310, 1'b0, 12935, 1'b1, 2);
    @(negedge Clk) Dog_X = 10'd500;
    px("hold", 50, 310, 1'b0, 12935, 1'b1, 2);

    // Edges of a sprite at (267,300); misses keep the previous address
    latch(267, 300, FR_SIT);
    px("left", 266, 300, 1'b0, 12935, 1'b0, 0);
    px("right", 331, 300, 1'b0, 12935, 1'b0, 0);
    px("bottom", 267, 348, 1'b0, 12935, 1'b0, 0);
    px("corner", 330, 347, 1'b0, 3071, 1'b1, 10);
    px("transp", 272, 300, 1'b0, 5, 1'b0, 0);

    // Same-edge frame_start: this pixel still sees x=267
    @(negedge Clk) Dog_X = 10'd400;
    px("same_old", 267, 300, 1'b1, 0, 1'b1, 5);
    px("same_miss", 267, 300, 1'b0, 0, 1'b0, 0);
    px("same_new", 400, 300, 1'b0, 0, 1'b1, 5);

    latch(267, 300, FR_JUMP2);
    chk("f8.err", 32'(frame_err), 0);
    px("f8", 267, 300, 1'b0, 24576, 1'b1, 5);
    latch(267, 300, 12);
    chk("f12.err", 32'(frame_err), 1);
    px("f12", 268, 300, 1'b0, 1, 1'b1, 4);
    latch(267, 300, FR_JUMP1);
    chk("sticky.err", 32'(frame_err), 1);
    px("f7", 268, 300, 1'b0, 21505, 1'b1, 4);

    // Back-to-back pixels, one output per cycle
    latch(267, 300, FR_SIT);
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (i < 3) begin
        DrawX = 10'(268 + i); DrawY = 10'd300; pix_valid = 1'b1;
      end else begin
        pix_valid = 1'b0;
      end
      @(posedge Clk); #1;
      if (i >= 3) begin
        chk($sformatf("stream%0d.on", i - 3), 32'(dog_on), 1);
        chk($sformatf("stream%0d.idx", i - 3), 32'(dog_idx), 32'(stream_idx[i-3]));
      end
    end

    // Reset with three hits in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      DrawX = 10'(268 + i); DrawY = 10'd300; pix_valid = 1'b1;
      @(posedge Clk);
    end
    @(negedge Clk) Reset = 1'b1;
    #1;
    chk("mid_rst.on", 32'(dog_on), 0);
    chk("mid_rst.addr", 32'(rom_addr), 0);
    chk("mid_rst.err", 32'(frame_err), 0);
    @(negedge Clk) Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      DrawX = 10'(268 + (i % 3)); DrawY = 10'd300; pix_valid = 1'b1;
      @(posedge Clk); #1;
      chk($sformatf("post_rst%0d.on", i), 32'(dog_on), 0);
    end
    pix_valid = 1'b0;
    latch(267, 300, FR_SIT);
    px("relatch", 269, 300, 1'b0, 2, 1'b1, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dog_sprite_renderer.md
Name: dog_sprite_renderer

Overview:
- Pixel-path stage directly downstream of the dog animation controller.
- Consumes dog screen position (Dog_X, Dog_Y) and animation Frame code.
- Snapshots them once per video frame, then, for every scanned pixel (DrawX, DrawY), computes a sprite-ROM address, waits out ROM latency and emits a palette index plus a dog_on hit flag to the colour mapper.
- Transparent texels produce dog_on = 0 so background/grass shows through.

Parameters:
- SPRITE_W, 64, sprite width in pixels.
- SPRITE_H, 48, sprite height in pixels.
- NUM_FRAMES, 9, number of frames stored in ROM (codes 0..8).
- PIX_W, 4, palette index width.
- TRANSPARENT_IDX, 0, palette index treated as transparent.
- ROM_LATENCY, 2, cycles from rom_addr to valid rom_data (1..3 supported).
- ADDR_W, $clog2(NUM_FRAMES*SPRITE_W*SPRITE_H) (=15), ROM address width.

Ports:
- Clk  in  1  system/pixel clock; one clock domain.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- Dog_X  in  10  dog top-left X from the controller.
- Dog_Y  in  10  dog top-left Y from the controller.
- Frame  in  5  animation frame code from the controller.
- DrawX  in  10  current scan X.
- DrawY  in  10  current scan Y.
- pix_valid  in  1  DrawX/DrawY are in active video.
- rom_addr  out  ADDR_W  sprite ROM read address.
- rom_data  in  PIX_W  ROM read data, ROM_LATENCY cycles after rom_addr.
- dog_on  out  1  current output pixel is opaque dog.
- dog_idx  out  PIX_W  palette index; 0 when dog_on = 0.
- frame_err  out  1  sticky flag: an out-of-range Frame was latched.

Behaviour:
- Reset (async, any time): shadow X/Y/Frame = 0, shadow_valid = 0, all pipeline valid/hit bits = 0, rom_addr = 0, dog_on = 0, dog_idx = 0, frame_err = 0. In-flight pixels are discarded; no stale dog_on after reset release.
- Shadow latch: on a Clk edge with frame_start = 1, capture Dog_X, Dog_Y and Frame, and set shadow_valid = 1. Values are held until the next frame_start, so controller changes mid-frame (ANIM_Clk domain already synchronised upstream) never tear the sprite.
- While shadow_valid = 0, dog_on = 0 for every pixel.
- Frame range:
  - If Frame >= NUM_FRAMES at latch, store 0 and set frame_err = 1.
  - frame_err stays set until Reset.
- Same-cycle event: with frame_start = 1 and pix_valid = 1 on one edge, that pixel uses the OLD shadow; the new shadow applies from the next cycle.
- Stage 1 (registered):
  - relx = DrawX - sx and rely = DrawY - sy, computed as 11-bit signed.
  - hit = pix_valid & shadow_valid & (0 <= relx < SPRITE_W) & (0 <= rely < SPRITE_H).
  - rom_addr = frame*SPRITE_W*SPRITE_H + rely*SPRITE_W + relx when hit; otherwise rom_addr holds its previous value.
- Right/bottom edge: sprites with sx + SPRITE_W > 1023 do not wrap. 11-bit arithmetic prevents DrawX near 0 aliasing into the sprite.
- Stages 2..1+ROM_LATENCY: hit is carried through a delay line of depth ROM_LATENCY, aligned with rom_data.
- Output (registered, same edge rom_data is valid):
  - dog_on = hit_d & (rom_data != TRANSPARENT_IDX).
  - dog_idx = dog_on ? rom_data : 0.
- Latency: DrawX/DrawY presented at edge n produce dog_on/dog_idx visible after edge n+1+ROM_LATENCY (3 cycles at default). Throughput is one pixel per cycle with no stalls; the mapper delays its background path to match.
- No backpressure: the ROM is assumed always ready.

Decomposition:
- Package dog_pkg holds:
  - SPRITE_W, SPRITE_H, NUM_FRAMES, PIX_W and TRANSPARENT_IDX defaults.
  - Frame code constants: FR_SIT=0, FR_WALK1=1, FR_WALK2=2, FR_WALK3=3, FR_SNIFF1=4, FR_SNIFF2=5, FR_SURPRISED=6, FR_JUMP1=7, FR_JUMP2=8. The controller and this block share these codes.
- One sub-module: pipe_delay, a parameterised width/depth register chain with async reset, used for the hit delay line.

Test Plan:
- Reset, then frame_start with Dog_X=11, Dog_Y=300, Frame=0; scan (11,300) -> rom_addr=0 one cycle later; with rom_data=5, dog_on=1 and dog_idx=5 three cycles after the pixel.
- Frame=4 latched, Dog_X=43, Dog_Y=300; pixel (50,310) -> rom_addr = 4*3072 + 10*64 + 7 = 12935.
- Boundaries, with sprite at (267,300): pixels (266,300), (331,300), (267,348) -> dog_on=0; pixels (330,347) -> hit, and dog_on=1 when rom_data is opaque.
- Transparency: hit pixel with rom_data=0 -> dog_on=0, dog_idx=0. Same-cycle test: change Dog_X with frame_start=1 on the same edge as pixel (267,300) -> old position used for that pixel only.
- Frame=12 latched -> frame_err=1, addresses use frame 0; a later valid Frame leaves frame_err=1; Reset clears it.
- Assert Reset for one cycle mid-scan while 3 pixels are in flight -> dog_on=0 for the next 3 outputs and until a new frame_start.
